// File: rtl/spi_pkg.sv
// Shared types and widths for the SPI byte receiver.
package spi_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned CNT_W  = $clog2(BYTE_W);

    typedef enum logic {
        IDLE,
        SHIFT
    } spi_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// Single-bit multi-flop synchronizer with a configurable reset (idle) level.
module sync_ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RST_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_byte_rx.sv
// SPI mode-0 slave byte receiver: oversampled bus, byte strobe plus frame-end/truncation flags.
module spi_byte_rx
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          LSB_FIRST   = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              spi_sclk_i,
    input  logic              spi_mosi_i,
    input  logic              spi_cs_n_i,
    input  logic              spi_dc_i,
    output logic              byte_vld_o,
    output logic [BYTE_W-1:0] byte_data_o,
    output logic              dc_o,
    output logic              frame_end_o,
    output logic              byte_err_o
);

    logic sclk_s;
    logic mosi_s;
    logic cs_n_s;
    logic dc_s;
    logic sclk_d;
    logic cs_n_d;
    logic sclk_rise;
    logic cs_rise;

    spi_rx_state_t     state;
    spi_rx_state_t     state_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  bit_cnt_nxt;
    logic [BYTE_W-1:0] shift_q;
    logic [BYTE_W-1:0] shift_nxt;
    logic [BYTE_W-1:0] shifted;
    logic              byte_vld_nxt;
    logic [BYTE_W-1:0] byte_data_nxt;
    logic              dc_nxt;
    logic              frame_end_nxt;
    logic              byte_err_nxt;

    // All four inputs share one depth so MOSI/DC line up with the SCLK edge.
    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_sclk_i),
        .q_o   (sclk_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_mosi_i),
        .q_o   (mosi_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_n_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_cs_n_i),
        .q_o   (cs_n_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_dc_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (spi_dc_i),
        .q_o   (dc_s)
    );

    assign sclk_rise = sclk_s & ~sclk_d;
    assign cs_rise   = cs_n_s & ~cs_n_d;

    // State, datapath and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_d      <= 1'b0;
            cs_n_d      <= 1'b1;
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_q     <= '0;
            byte_vld_o  <= 1'b0;
            byte_data_o <= '0;
            dc_o        <= 1'b0;
            frame_end_o <= 1'b0;
            byte_err_o  <= 1'b0;
        end else begin
            sclk_d      <= sclk_s;
            cs_n_d      <= cs_n_s;
            state       <= state_nxt;
            bit_cnt     <= bit_cnt_nxt;
            shift_q     <= shift_nxt;
            byte_vld_o  <= byte_vld_nxt;
            byte_data_o <= byte_data_nxt;
            dc_o        <= dc_nxt;
            frame_end_o <= frame_end_nxt;
            byte_err_o  <= byte_err_nxt;
        end
    end

    // Next-state and output decode; a CS_N rise pre-empts a coincident SCLK rise.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift_q;
        byte_vld_nxt  = 1'b0;
        byte_data_nxt = byte_data_o;
        dc_nxt        = dc_o;
        frame_end_nxt = 1'b0;
        byte_err_nxt  = 1'b0;
        shifted       = LSB_FIRST ? {mosi_s, shift_q[BYTE_W-1:1]}
                                  : {shift_q[BYTE_W-2:0], mosi_s};

        case (state)
            IDLE: begin
                bit_cnt_nxt = '0;
                if (!cs_n_s) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cs_rise) begin
                    state_nxt     = IDLE;
                    frame_end_nxt = 1'b1;
                    byte_err_nxt  = (bit_cnt != '0);
                    bit_cnt_nxt   = '0;
                end else if (sclk_rise) begin
                    shift_nxt   = shifted;
                    bit_cnt_nxt = bit_cnt + CNT_W'(1);
                    if (bit_cnt == CNT_W'(BYTE_W - 1)) begin
                        byte_vld_nxt  = 1'b1;
                        byte_data_nxt = shifted;
                        dc_nxt        = dc_s;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_byte_rx.sv
// Randomized bench for spi_byte_rx: an SPI bus driver predicts outputs from the wire bits it sends.
`timescale 1ns/1ps
module tb_spi_byte_rx;

    localparam int SYNC_STAGES = 2;
    localparam int EV_RST  = 0;
    localparam int EV_BYTE = 1;
    localparam int EV_FE   = 2;
    localparam int EV_ERR  = 3;

    typedef struct {
        int         cyc;
        int         kind;
        logic [7:0] d0;
        logic [7:0] d1;
        logic       dc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic spi_sclk = 1'b0;
    logic spi_mosi = 1'b0;
    logic spi_cs_n = 1'b1;
    logic spi_dc = 1'b0;

    logic       vld0, vld1, dco0, dco1, fe0, fe1, err0, err1;
    logic [7:0] data0, data1;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    ev_t evq[$];
    bit  chk_en = 1'b0;
    logic [7:0] m_d0 = 8'h00;
    logic [7:0] m_d1 = 8'h00;
    logic       m_dc = 1'b0;

    // driver-side view of the frame
    bit         frame_active = 1'b0;
    int         bit_pos = 0;
    logic [7:0] wire_bits = 8'h00;

    // observed statistics
    int n_vld0 = 0, n_vld1 = 0, n_fe0 = 0, n_err0 = 0;
    int last_vld_cyc = -1000;
    int min_gap = 1000000;
    logic vld0_prev = 1'b0;

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES), .LSB_FIRST(1'b0)) u_dut_msb (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi_sclk_i  (spi_sclk),
        .spi_mosi_i  (spi_mosi),
        .spi_cs_n_i  (spi_cs_n),
        .spi_dc_i    (spi_dc),
        .byte_vld_o  (vld0),
        .byte_data_o (data0),
        .dc_o        (dco0),
        .frame_end_o (fe0),
        .byte_err_o  (err0)
    );

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES), .LSB_FIRST(1'b1)) u_dut_lsb (
        .clk_i       (clk),
        .rst_i       (rst),
        .spi_sclk_i  (spi_sclk),
        .spi_mosi_i  (spi_mosi),
        .spi_cs_n_i  (spi_cs_n),
        .spi_dc_i    (spi_dc),
        .byte_vld_o  (vld1),
        .byte_data_o (data1),
        .dc_o        (dco1),
        .frame_end_o (fe1),
        .byte_err_o  (err1)
    );

    always #2.5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Expected behaviour: every event the driver predicted lands on exactly its cycle.
    always @(negedge clk) begin
        bit exp_vld, exp_fe, exp_err;
        ev_t ev;
        exp_vld = 1'b0;
        exp_fe  = 1'b0;
        exp_err = 1'b0;
        while (evq.size() > 0 && evq[0].cyc <= cyc) begin
            ev = evq.pop_front();
            case (ev.kind)
                EV_RST:  begin chk_en = 1'b1; m_d0 = 8'h00; m_d1 = 8'h00; m_dc = 1'b0; end
                EV_BYTE: begin exp_vld = 1'b1; m_d0 = ev.d0; m_d1 = ev.d1; m_dc = ev.dc; end
                EV_FE:   exp_fe = 1'b1;
                default: exp_err = 1'b1;
            endcase
        end
        if (chk_en) begin
            chk("vld_msb", 32'(vld0), 32'(exp_vld));
            chk("vld_lsb", 32'(vld1), 32'(exp_vld));
            chk("data_msb", 32'(data0), 32'(m_d0));
            chk("data_lsb", 32'(data1), 32'(m_d1));
            chk("dc_msb", 32'(dco0), 32'(m_dc));
            chk("dc_lsb", 32'(dco1), 32'(m_dc));
            chk("frame_end_msb", 32'(fe0), 32'(exp_fe));
            chk("frame_end_lsb", 32'(fe1), 32'(exp_fe));
            chk("byte_err_msb", 32'(err0), 32'(exp_err));
            chk("byte_err_lsb", 32'(err1), 32'(exp_err));
            if (vld0 && vld0_prev) begin
                chk("vld_back_to_back", 32'(1), 32'(0));
            end
            if (vld0) begin
                if (cyc - last_vld_cyc < min_gap) min_gap = cyc - last_vld_cyc;
                last_vld_cyc = cyc;
                n_vld0++;
            end
            if (vld1) n_vld1++;
            if (fe0) n_fe0++;
            if (err0) n_err0++;
            vld0_prev = vld0;
        end
    end

    task automatic wait_cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_ev(input int c, input int kind);
        ev_t e;
        e.cyc = c; e.kind = kind; e.d0 = 8'h00; e.d1 = 8'h00; e.dc = 1'b0;
        evq.push_back(e);
    endtask

    // Wire bit k is the k-th bit shifted; MSB-first puts it at 7-k, LSB-first at k.
    task automatic push_byte(input int c, input logic dcv);
        ev_t e;
        e.cyc = c; e.kind = EV_BYTE; e.dc = dcv; e.d0 = 8'h00; e.d1 = 8'h00;
        for (int j = 0; j < 8; j++) begin
            e.d0 = e.d0 | (8'(wire_bits[j]) << (7 - j));
            e.d1 = e.d1 | (8'(wire_bits[j]) << j);
        end
        evq.push_back(e);
    endtask

    task automatic send_bits(input logic [7:0] w, input int n, input bit lsb_wire,
                             input logic dcv, input int half);
        for (int k = 0; k < n; k++) begin
            logic b;
            b = lsb_wire ? w[k] : w[7-k];
            spi_sclk = 1'b0;
            spi_mosi = b;
            spi_dc   = dcv;
            wait_cyc(half);
            spi_sclk = 1'b1;
            if (frame_active) begin
                wire_bits[bit_pos] = b;
                bit_pos++;
                if (bit_pos == 8) begin
                    push_byte(cyc + 1 + SYNC_STAGES, dcv);
                    bit_pos = 0;
                end
            end
            wait_cyc(half);
        end
    endtask

    task automatic cs_low();
        spi_cs_n = 1'b0;
        wait_cyc(8);
        frame_active = 1'b1;
        bit_pos = 0;
    endtask

    task automatic cs_high();
        spi_cs_n = 1'b1;
        if (frame_active) begin
            push_ev(cyc + 1 + SYNC_STAGES, EV_FE);
            if (bit_pos != 0) push_ev(cyc + 1 + SYNC_STAGES, EV_ERR);
        end
        frame_active = 1'b0;
        bit_pos = 0;
        wait_cyc(8);
    endtask

    // CS_N still low after reset puts the receiver straight back into a frame.
    task automatic do_reset();
        rst = 1'b1;
        push_ev(cyc + 1, EV_RST);
        wait_cyc(1);
        rst = 1'b0;
        bit_pos = 0;
        frame_active = (spi_cs_n == 1'b0);
        wait_cyc(8);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int b_vld, b_fe, b_err;
        wait_cyc(2);
        do_reset();
        chk("reset_data", 32'(data0), 32'h0);
        chk("reset_vld_count", 32'(n_vld0), 32'd0);

        // 1: single command byte
        b_vld = n_vld0; b_fe = n_fe0; b_err = n_err0;
        cs_low();
        send_bits(8'h2A, 8, 1'b0, 1'b0, 4);
        cs_high();
        chk("t1_count", 32'(n_vld0 - b_vld), 32'd1);
        chk("t1_data", 32'(data0), 32'h2A);
        chk("t1_dc", 32'(dco0), 32'h0);
        chk("t1_frame_end", 32'(n_fe0 - b_fe), 32'd1);
        chk("t1_no_err", 32'(n_err0 - b_err), 32'd0);

        // 2: four data bytes in one window
        b_vld = n_vld0; min_gap = 1000000;
        cs_low();
        send_bits(8'h01, 8, 1'b0, 1'b1, 4);
        send_bits(8'h12, 8, 1'b0, 1'b1, 4);
        send_bits(8'h23, 8, 1'b0, 1'b1, 4);
        send_bits(8'h34, 8, 1'b0, 1'b1, 4);
        cs_high();
        chk("t2_count", 32'(n_vld0 - b_vld), 32'd4);
        chk("t2_data", 32'(data0), 32'h34);
        chk("t2_dc", 32'(dco0), 32'h1);
        chk("t2_gap_ge32", 32'(min_gap >= 32), 32'd1);

        // 3: truncated byte then a clean one
        b_vld = n_vld0; b_fe = n_fe0; b_err = n_err0;
        cs_low();
        send_bits(8'hFF, 5, 1'b0, 1'b0, 4);
        cs_high();
        chk("t3_no_vld", 32'(n_vld0 - b_vld), 32'd0);
        chk("t3_err", 32'(n_err0 - b_err), 32'd1);
        chk("t3_frame_end", 32'(n_fe0 - b_fe), 32'd1);
        cs_low();
        send_bits(8'h55, 8, 1'b0, 1'b0, 4);
        cs_high();
        chk("t3_data", 32'(data0), 32'h55);

        // 4: reset in the middle of a byte
        b_vld = n_vld0;
        cs_low();
        send_bits(8'hA5, 4, 1'b0, 1'b1, 4);
        spi_sclk = 1'b0;
        wait_cyc(4);
        rst = 1'b1;
        push_ev(cyc + 1, EV_RST);
        wait_cyc(1);
        rst = 1'b0;
        chk("t4_reset_data", 32'(data0), 32'h0);
        chk("t4_reset_vld", 32'(vld0), 32'h0);
        bit_pos = 0;
        frame_active = 1'b1;
        wait_cyc(8);
        cs_high();
        chk("t4_no_vld", 32'(n_vld0 - b_vld), 32'd0);
        cs_low();
        send_bits(8'h3C, 8, 1'b0, 1'b0, 4);
        cs_high();
        chk("t4_data", 32'(data0), 32'h3C);

        // 5: LSB-first wire order, then clocks with CS_N high
        cs_low();
        send_bits(8'h01, 8, 1'b1, 1'b1, 4);
        cs_high();
        chk("t5_lsb_data", 32'(data1), 32'h01);
        chk("t5_msb_view", 32'(data0), 32'h80);
        b_vld = n_vld1;
        send_bits(8'hC3, 8, 1'b0, 1'b0, 3);
        send_bits(8'h5A, 8, 1'b0, 1'b1, 2);
        wait_cyc(8);
        chk("t5_cs_high_no_vld", 32'(n_vld1 - b_vld), 32'd0);

        // 6: 256-byte stream
        b_vld = n_vld0;
        cs_low();
        for (int i = 0; i < 256; i++) begin
            send_bits(8'(i % 255), 8, 1'b0, 1'b1, 4);
        end
        cs_high();
        chk("t6_count", 32'(n_vld0 - b_vld), 32'd256);
        chk("t6_last", 32'(data0), 32'h00);

        // randomized traffic: varying SCLK rate, D/C, truncations and frame breaks
        cs_low();
        for (int i = 0; i < 60; i++) begin
            int half, r;
            half = int'($urandom_range(2, 5));
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                send_bits(8'($urandom), int'($urandom_range(1, 7)), 1'b0, 1'($urandom), half);
                cs_high();
                cs_low();
            end else begin
                send_bits(8'($urandom), 8, 1'($urandom), 1'($urandom), half);
                if (r == 1) begin
                    cs_high();
                    cs_low();
                end
            end
        end
        cs_high();
        wait_cyc(10);
        chk("queue_drained", 32'(evq.size()), 32'd0);
        chk("lsb_msb_count_match", 32'(n_vld1), 32'(n_vld0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
